// File: rtl/or_reduce_arbiter.sv
// or_reduce_arbiter: arbitrates REQ clients onto one shared parallel_or unit and
// returns each WIRE-bit result, tagged with the winning index, over a ready/valid channel.
// Build option: define OR_ARB_RR_EN for round-robin arbitration; when it is
// undefined, the lowest asserted request index always wins.

module parallel_or #(
  parameter int WAY  = 2,
  parameter int WIRE = 2
) (
  input  logic [WAY*WIRE-1:0] in_i,
  output logic [WIRE-1:0]     out_o
);

  // Each output bit is the OR of its own WAY-bit slice of the operand.
  always_comb begin
    out_o = '0;
    for (int k = 0; k < WIRE; k++) begin
      out_o[k] = |in_i[k*WAY +: WAY];
    end
  end

endmodule

module or_reduce_arbiter #(
  parameter int REQ  = 4,
  parameter int WAY  = 2,
  parameter int WIRE = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [REQ-1:0]              req,
  input  logic [REQ*WAY*WIRE-1:0]     data,
  output logic [REQ-1:0]              gnt,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [WIRE-1:0]             res,
  output logic [$clog2(REQ)-1:0]      res_id
);

  localparam int SIZE = WAY * WIRE;
  localparam int IDW  = $clog2(REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_q;
  logic            calc_ph_q;
  logic [SIZE-1:0] op_q;
  logic [IDW-1:0]  id_q;
  logic [WIRE-1:0] red_q;
  logic [REQ-1:0]  gnt_q;
  logic            busy_q;
  logic            res_valid_q;
  logic [WIRE-1:0] res_q;
  logic [IDW-1:0]  res_id_q;

  logic            win_vld_s;
  logic [IDW-1:0]  win_idx_s;
  logic [SIZE-1:0] win_op_s;
  logic [REQ-1:0]  win_onehot_s;
  logic [WIRE-1:0] po_s;

`ifdef OR_ARB_RR_EN
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [IDW:0]    pos_s;

  // Rotating search from ptr_q; walking downward lets the slot nearest ptr_q win.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = '0;
    pos_s     = '0;
    for (int k = REQ - 1; k >= 0; k--) begin
      pos_s     = {1'b0, ptr_q} + (IDW+1)'(k);
      pos_s     = (pos_s >= (IDW+1)'(REQ)) ? (pos_s - (IDW+1)'(REQ)) : pos_s;
      win_vld_s = req[pos_s[IDW-1:0]] ? 1'b1 : win_vld_s;
      win_idx_s = req[pos_s[IDW-1:0]] ? pos_s[IDW-1:0] : win_idx_s;
    end
  end

  // After a completed result the search restarts just past the served requester.
  always_comb begin
    if (id_q == IDW'(REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = id_q + IDW'(1);
    end
  end
`else
  // Fixed priority: walking downward lets the lowest asserted index win.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = '0;
    for (int k = REQ - 1; k >= 0; k--) begin
      win_vld_s = req[k] ? 1'b1 : win_vld_s;
      win_idx_s = req[k] ? IDW'(k) : win_idx_s;
    end
  end
`endif

  // Select the winning requester's operand slice.
  always_comb begin
    win_op_s = '0;
    for (int k = 0; k < REQ; k++) begin
      win_op_s = (win_idx_s == IDW'(k)) ? data[k*SIZE +: SIZE] : win_op_s;
    end
  end

  // One-hot grant pattern for the winning index.
  always_comb begin
    win_onehot_s = {{(REQ-1){1'b0}}, 1'b1} << win_idx_s;
  end

  parallel_or #(
    .WAY  (WAY),
    .WIRE (WIRE)
  ) u_parallel_or (
    .in_i  (op_q),
    .out_o (po_s)
  );

  // Arbiter FSM: capture in IDLE, two-phase reduction in CALC, result handshake in HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      calc_ph_q   <= 1'b0;
      op_q        <= '0;
      id_q        <= '0;
      red_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_id_q    <= '0;
`ifdef OR_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_vld_s) begin
            op_q      <= win_op_s;
            id_q      <= win_idx_s;
            gnt_q     <= win_onehot_s;
            busy_q    <= 1'b1;
            calc_ph_q <= 1'b0;
            state_q   <= ST_CALC;
          end else begin
            gnt_q     <= '0;
          end
        end
        ST_CALC: begin
          gnt_q <= '0;
          // The shared unit's output is registered once before it reaches res.
          if (!calc_ph_q) begin
            red_q     <= po_s;
            calc_ph_q <= 1'b1;
          end else begin
            res_q       <= red_q;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            calc_ph_q   <= 1'b0;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          gnt_q <= '0;
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef OR_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
            state_q     <= ST_IDLE;
          end else begin
            state_q     <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res       = res_q;
  assign res_id    = res_id_q;

endmodule
